ov7670_cfg_seq: RTL
===================

// Module: ov7670_cfg_seq
// PURPOSE
//   Register-init sequencer for the OV7670 camera; sits directly upstream of the SCCB/IIC write engine.
//   Waits for sensor power-up, then walks an external register ROM of {reg_addr, reg_val} pairs.
//   Each entry is handed to the engine as one start pulse plus {DEV_ID, reg_addr, reg_val}.
//   Reports done/error to the capture path, which must stay off until cfg_done.
// PARAMETERS
//   DEV_ID        8'h42      SCCB write ID placed in iic_wdata[23:16]
//   REG_NUM       8'd165     number of ROM entries; indices 0..REG_NUM-1
//   PWRUP_CYC     1_000_000  clk cycles idle after reset before first entry (20 ms @ 50 MHz)
//   SRST_CYC      50_000     extra wait after any write of COM7 (0x12) with bit7 set (soft reset)
//   GAP_CYC       200        idle cycles between consecutive transactions
//   ACK_CYC       8          max cycles from iic_start to iic_busy high
//   TOUT_CYC      65_536     max cycles iic_busy may stay high
// PORTS
//   clk          in   1   system clock, 50 MHz
//   rst          in   1   reset, synchronous, active-high
//   cfg_restart  in   1   1-cycle pulse; restarts the sequence from power-up wait
//   rom_addr     out  8   ROM index
//   rom_data     in  16   {reg_addr[15:8], reg_val[7:0]}; valid 1 clk after rom_addr
//   iic_start    out  1   1-cycle start pulse to the IIC engine
//   iic_wdata    out 24   {DEV_ID, rom_data}; stable from iic_start until busy falls
//   iic_busy     in   1   engine busy; rises the cycle after start, falls when the stop is done
//   cfg_done     out  1   level; all REG_NUM entries written
//   cfg_err      out  1   level; handshake timeout, sequence halted
//   cfg_cnt      out  8   entries completed so far
// BEHAVIOUR
//   Reset: state=PWRUP, counter cleared; all outputs 0 (rom_addr=0, iic_wdata=0).
//   Shared delay counter, at least 20 bits wide; reloaded on every state entry.
//   FSM:
//   - PWRUP: count PWRUP_CYC cycles -> FETCH.
//   - FETCH: drive rom_addr=cfg_cnt; wait 2 cycles (ROM latency plus capture) -> LOAD.
//   - LOAD: iic_wdata<={DEV_ID,rom_data}; iic_start=1 this cycle only -> WAIT_H.
//   - WAIT_H: if iic_busy -> WAIT_L; if ACK_CYC elapses without it -> ERR.
//   - WAIT_L: if !iic_busy -> POST, with cfg_cnt+1; if TOUT_CYC elapses with busy still high -> ERR.
//   - POST: if last written reg_addr==8'h12 and reg_val[7]==1, wait SRST_CYC, else GAP_CYC.
//     Then DONE if cfg_cnt==REG_NUM, else FETCH.
//   - DONE: cfg_done=1; hold.
//   - ERR: cfg_err=1; iic_start stays 0; hold.
//   Rules and boundary cases:
//   - iic_start is never asserted while iic_busy=1 or during a state other than LOAD.
//   - Only one start per entry; failed entries are never retried.
//   - REG_NUM=0: PWRUP -> DONE directly, with no start pulses.
//   - cfg_cnt saturates at REG_NUM; rom_addr never exceeds REG_NUM-1.
//   - cfg_restart in any state: -> PWRUP; cfg_cnt, cfg_done, cfg_err cleared next cycle.
//   - If cfg_restart arrives while the engine is busy, the next start is still withheld until iic_busy is low.
//   - rst and cfg_restart together: rst wins (identical result).
//   - Latency per entry = 3 + busy duration + GAP/SRST wait, in cycles.
// TESTING
//   (Benches use PWRUP_CYC=100, GAP_CYC=10, SRST_CYC=50, REG_NUM=3, and an IIC engine model with busy=40 cycles.)
//   1. ROM={1280,1100,3A04} -> three starts carrying 421280, 421100, 423A04.
//      First start at cycle 103 after rst release. Gap after entry 0 >= 50 cycles.
//      cfg_done=1, cfg_cnt=3.
//   2. Engine model never raises busy -> cfg_err=1 at start+8 cycles.
//      Only one iic_start is seen; cfg_done stays 0.
//   3. Busy held high for 70000 cycles -> cfg_err asserts 65536 cycles after busy rose.
//   4. cfg_restart pulsed during WAIT_L of entry 1 -> cfg_cnt=0.
//      Next start is no earlier than busy fall + 100 cycles, and carries entry 0.
//   5. REG_NUM=0 -> cfg_done=1 at cycle 101 after reset, with zero iic_start pulses.
//   6. rst asserted mid-sequence -> all outputs 0 next cycle; full sequence replays from entry 0.

Source files
------------

// File: rtl/ov7670_cfg_seq_if.sv
// Bus bundle between the OV7670 init sequencer, its register ROM, the SCCB write engine
// and the capture-path status consumer.
interface ov7670_cfg_seq_if;
    logic        cfg_restart;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic        iic_start;
    logic [23:0] iic_wdata;
    logic        iic_busy;
    logic        cfg_done;
    logic        cfg_err;
    logic [7:0]  cfg_cnt;

    // Sequencer side
    modport master (
        input  cfg_restart, rom_data, iic_busy,
        output rom_addr, iic_start, iic_wdata, cfg_done, cfg_err, cfg_cnt
    );

    // ROM / engine / status side
    modport slave (
        output cfg_restart, rom_data, iic_busy,
        input  rom_addr, iic_start, iic_wdata, cfg_done, cfg_err, cfg_cnt
    );
endinterface

// File: rtl/ov7670_cfg_seq.sv
// OV7670 register-init sequencer: waits for sensor power-up, then walks a ROM of
// {reg_addr, reg_val} pairs, handing each to the SCCB write engine as one start pulse.
module ov7670_cfg_seq #(
    parameter logic [7:0]  DEV_ID    = 8'h42,
    parameter int unsigned REG_NUM   = 165,
    parameter int unsigned PWRUP_CYC = 1_000_000,
    parameter int unsigned SRST_CYC  = 50_000,
    parameter int unsigned GAP_CYC   = 200,
    parameter int unsigned ACK_CYC   = 8,
    parameter int unsigned TOUT_CYC  = 65_536
) (
    input logic              clk_i,
    input logic              rst_i,
    ov7670_cfg_seq_if.master bus
);

    localparam int unsigned CntW = 24;
    typedef logic [CntW-1:0] dly_t;

    // Terminal values of the shared up-counter (cleared on every state entry).
    // The handshake windows are measured from the start cycle, which is spent in LOAD,
    // so the wait states themselves run one cycle shorter.
    localparam dly_t       PwrupLim = dly_t'(PWRUP_CYC - 1);
    localparam dly_t       FetchLim = dly_t'(1);
    localparam dly_t       AckLim   = dly_t'(ACK_CYC - 2);
    localparam dly_t       ToutLim  = dly_t'(TOUT_CYC - 2);
    localparam dly_t       GapLim   = dly_t'(GAP_CYC - 1);
    localparam dly_t       SrstLim  = dly_t'(SRST_CYC - 1);
    localparam logic [7:0] RegNum   = 8'(REG_NUM);

    typedef enum logic [2:0] {
        StPwrup,
        StFetch,
        StLoad,
        StWaitH,
        StWaitL,
        StPost,
        StDone,
        StErr
    } state_e;

    state_e      state_q, state_d;
    dly_t        dly_q, dly_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  rom_addr_q, rom_addr_d;
    logic [23:0] wdata_q, wdata_d;
    logic        dly_clr;
    logic        start;
    logic        srst_wr;

    // Last write was COM7 with the soft-reset bit set
    assign srst_wr = (wdata_q[15:8] == 8'h12) && wdata_q[7];

    // Next-state, counter and datapath updates
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rom_addr_d = rom_addr_q;
        wdata_d    = wdata_q;
        dly_clr    = 1'b0;
        start      = 1'b0;
        dly_d      = dly_q;

        case (state_q)
            StPwrup: begin
                // Power-up count only runs once the engine is idle, so a restart that
                // lands mid-write still gets the full quiet period after the stop.
                if (bus.iic_busy) begin
                    dly_clr = 1'b1;
                end else if (dly_q == PwrupLim) begin
                    if (RegNum == 8'd0) begin
                        state_d = StDone;
                    end else begin
                        state_d    = StFetch;
                        rom_addr_d = cnt_q;
                    end
                end
            end
            StFetch: begin
                if (dly_q == FetchLim) begin
                    state_d = StLoad;
                    wdata_d = {DEV_ID, bus.rom_data};
                end
            end
            StLoad: begin
                if (!bus.iic_busy) begin
                    start   = 1'b1;
                    state_d = StWaitH;
                end
            end
            StWaitH: begin
                if (bus.iic_busy) begin
                    state_d = StWaitL;
                end else if (dly_q == AckLim) begin
                    state_d = StErr;
                end
            end
            StWaitL: begin
                if (!bus.iic_busy) begin
                    state_d = StPost;
                    if (cnt_q < RegNum) begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end else if (dly_q == ToutLim) begin
                    state_d = StErr;
                end
            end
            StPost: begin
                if (dly_q == (srst_wr ? SrstLim : GapLim)) begin
                    if (cnt_q >= RegNum) begin
                        state_d = StDone;
                    end else begin
                        state_d    = StFetch;
                        rom_addr_d = cnt_q;
                    end
                end
            end
            StDone:  state_d = StDone;
            StErr:   state_d = StErr;
            default: state_d = StPwrup;
        endcase

        if (bus.cfg_restart) begin
            state_d    = StPwrup;
            cnt_d      = 8'd0;
            rom_addr_d = 8'd0;
            dly_clr    = 1'b1;
            start      = 1'b0;
        end

        if (state_d != state_q) begin
            dly_clr = 1'b1;
        end

        if (dly_clr) begin
            dly_d = '0;
        end else if (state_q inside {StPwrup, StFetch, StWaitH, StWaitL, StPost}) begin
            dly_d = dly_q + 1'b1;
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StPwrup;
            dly_q      <= '0;
            cnt_q      <= 8'd0;
            rom_addr_q <= 8'd0;
            wdata_q    <= 24'd0;
        end else begin
            state_q    <= state_d;
            dly_q      <= dly_d;
            cnt_q      <= cnt_d;
            rom_addr_q <= rom_addr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign bus.iic_start = start;
    assign bus.iic_wdata = wdata_q;
    assign bus.rom_addr  = rom_addr_q;
    assign bus.cfg_cnt   = cnt_q;
    assign bus.cfg_done  = (state_q == StDone);
    assign bus.cfg_err   = (state_q == StErr);

endmodule
